// File: rtl/alu_pkg.sv
// Shared opcode map, state encoding and flag layout for the sequential ALU.
package alu_pkg;

    localparam logic [2:0] OP_NEG   = 3'd0;
    localparam logic [2:0] OP_INC   = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_ADDSH = 3'd3;
    localparam logic [2:0] OP_AND   = 3'd4;
    localparam logic [2:0] OP_OR    = 3'd5;
    localparam logic [2:0] OP_CAT   = 3'd6;
    localparam logic [2:0] OP_MUL   = 3'd7;

    typedef enum logic [0:0] {
        IDLE,
        MUL
    } state_e;

    typedef struct packed {
        logic zer;
        logic neg;
        logic cout;
        logic ovf;
    } flags_t;

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle between the register file, the ALU and writeback.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = 4
);
    logic             start;
    logic [2:0]       opc;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             C;
    logic             use_cf;
    logic [SHW-1:0]   SHAMT;
    logic             in_ready;
    logic             done;
    logic [WIDTH-1:0] W;
    logic [WIDTH-1:0] res_hi;
    logic             zer;
    logic             neg;
    logic             cout;
    logic             ovf;

    modport master (
        output start, opc, A, B, C, use_cf, SHAMT,
        input  in_ready, done, W, res_hi, zer, neg, cout, ovf
    );

    modport slave (
        input  start, opc, A, B, C, use_cf, SHAMT,
        output in_ready, done, W, res_hi, zer, neg, cout, ovf
    );
endinterface

// File: rtl/alu_mul_step.sv
// One shift-add multiply iteration: conditionally add the multiplicand to the
// accumulator high half. The caller shifts the (WIDTH+1)-bit sum right.
module alu_mul_step #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mcand,
    input  logic             mbit,
    output logic [WIDTH:0]   acc_nxt
);

    // Keep the carry so no product bit is lost for full-range operands
    always_comb begin
        acc_nxt = {1'b0, acc} + (mbit ? {1'b0, mcand} : '0);
    end

endmodule

// File: rtl/alu_seq.sv
// Registered multi-cycle ALU: single-cycle ops 0-6, iterative unsigned MUL,
// carry flag chaining for multi-word adds.
module alu_seq import alu_pkg::*; #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = 4
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);

    localparam int unsigned      CW  = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX = {1'b0, {(WIDTH-1){1'b1}}};

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] hi_q;
    flags_t           flags_q;
    logic             done_q;

    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res_w;
    flags_t           res_f;

    logic [WIDTH:0]   step_sum;
    logic [WIDTH-1:0] prod_hi;
    logic [WIDTH-1:0] prod_lo;
    flags_t           mul_f;

    // Single-cycle datapath for ops 0-6, evaluated on the live operands
    always_comb begin
        if (32'(bus.SHAMT) >= WIDTH) begin
            sh_b = {WIDTH{bus.B[WIDTH-1]}};
        end else begin
            sh_b = $signed(bus.B) >>> bus.SHAMT;
        end
        add_b   = (bus.opc == OP_ADDSH) ? sh_b : bus.B;
        add_cin = (bus.opc == OP_ADD) ? (bus.use_cf ? flags_q.cout : bus.C) : 1'b0;
        sum     = {1'b0, bus.A} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

        res_w      = '0;
        res_f.cout = 1'b0;
        res_f.ovf  = 1'b0;
        case (bus.opc)
            OP_NEG: begin
                res_w      = ~bus.A + ONE;
                res_f.cout = (bus.A == '0);
                res_f.ovf  = (bus.A == MIN);
            end
            OP_INC: begin
                res_w      = bus.A + ONE;
                res_f.cout = (bus.A == '1);
                res_f.ovf  = (bus.A == MAX);
            end
            OP_ADD, OP_ADDSH: begin
                res_w      = sum[WIDTH-1:0];
                res_f.cout = sum[WIDTH];
                res_f.ovf  = (bus.A[WIDTH-1] == add_b[WIDTH-1]) &&
                             (sum[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_AND: res_w = bus.A & bus.B;
            OP_OR:  res_w = bus.A | bus.B;
            OP_CAT: res_w = {bus.A[WIDTH/2-1:0], bus.B[WIDTH/2-1:0]};
            default: res_w = '0;
        endcase
        res_f.zer = (res_w == '0);
        res_f.neg = res_w[WIDTH-1];
    end

    alu_mul_step #(
        .WIDTH (WIDTH)
    ) u_mul_step (
        .acc     (acc_q),
        .mcand   (mcand_q),
        .mbit    (mplier_q[0]),
        .acc_nxt (step_sum)
    );

    // Product as it stands after this edge's step; valid as the result on the last step
    always_comb begin
        prod_hi    = step_sum[WIDTH:1];
        prod_lo    = {step_sum[0], mplier_q[WIDTH-1:1]};
        mul_f.zer  = (prod_lo == '0);
        mul_f.neg  = prod_lo[WIDTH-1];
        mul_f.cout = (prod_hi != '0);
        mul_f.ovf  = (prod_hi != '0);
    end

    // Control FSM with registered results and one-cycle done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            w_q      <= '0;
            hi_q     <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.opc == OP_MUL) begin
                            mcand_q  <= bus.A;
                            mplier_q <= bus.B;
                            acc_q    <= '0;
                            cnt_q    <= CW'(WIDTH);
                            state_q  <= MUL;
                        end else begin
                            w_q     <= res_w;
                            hi_q    <= '0;
                            flags_q <= res_f;
                            done_q  <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    // {acc, multiplier} shifts right one bit per step
                    acc_q    <= prod_hi;
                    mplier_q <= prod_lo;
                    cnt_q    <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        w_q     <= prod_lo;
                        hi_q    <= prod_hi;
                        flags_q <= mul_f;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready = (state_q == IDLE);
    assign bus.done     = done_q;
    assign bus.W        = w_q;
    assign bus.res_hi   = hi_q;
    assign bus.zer      = flags_q.zer;
    assign bus.neg      = flags_q.neg;
    assign bus.cout     = flags_q.cout;
    assign bus.ovf      = flags_q.ovf;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: table of single-cycle ops issued back-to-back,
// then hand-written MUL, ignored-start and reset-abort sequences.
module tb_alu_seq;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(16), .SHW(4)) bus ();

    alu_seq #(
        .WIDTH (16),
        .SHW   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [2:0]  opc;
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic        ucf;
        logic [3:0]  sh;
        logic [15:0] w;
        logic [3:0]  f;   // {zer, neg, cout, ovf}
    } vec_t;

    localparam int NV = 17;
    vec_t vecs[NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] opc, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic ucf, input logic [3:0] sh);
        bus.start  = 1'b1;
        bus.opc    = opc;
        bus.A      = a;
        bus.B      = b;
        bus.C      = c;
        bus.use_cf = ucf;
        bus.SHAMT  = sh;
    endtask

    task automatic chk_result(input string nm, input logic [15:0] w, input logic [15:0] hi,
                              input logic [3:0] f);
        chk({nm, ".W"}, 32'(bus.W), 32'(w));
        chk({nm, ".res_hi"}, 32'(bus.res_hi), 32'(hi));
        chk({nm, ".flags"}, 32'({bus.zer, bus.neg, bus.cout, bus.ovf}), 32'(f));
    endtask

    // Issue a MUL, optionally pulse a stray start or assert reset mid-flight
    task automatic run_mul(input string nm, input logic [15:0] a, input logic [15:0] b,
                           output int lat, output int low);
        lat = -1;
        low = 0;
        @(negedge clk);
        drive(OP_MUL, a, b, 1'b0, 1'b0, 4'd0);
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            @(negedge clk);
            if (n == 1) begin
                bus.start = 1'b0;
                bus.A     = 16'hDEAD;   // must not disturb the latched operands
                bus.B     = 16'hBEEF;
            end
            if (bus.done) lat = n;
            else if (!bus.in_ready) low++;
            if (n == 5) drive(OP_ADD, 16'h1111, 16'h2222, 1'b0, 1'b0, 4'd0);
            if (n == 6) bus.start = 1'b0;
        end
        if (lat < 0) begin
            errors++;
            $display("FAIL %s.timeout: got no done expected done within 40 cycles", nm);
        end
    endtask

    initial begin
        int lat;
        int low;
        int ndone;

        vecs[0]  = '{OP_ADD,   16'h7FFF, 16'h0001, 1'b0, 1'b0, 4'd0,  16'h8000, 4'b0101};
        vecs[1]  = '{OP_ADD,   16'hFFFF, 16'h0001, 1'b0, 1'b0, 4'd0,  16'h0000, 4'b1010};
        vecs[2]  = '{OP_ADD,   16'h0000, 16'h0000, 1'b0, 1'b1, 4'd0,  16'h0001, 4'b0000};
        vecs[3]  = '{OP_ADDSH, 16'h0010, 16'h8000, 1'b0, 1'b0, 4'd4,  16'hF810, 4'b0100};
        vecs[4]  = '{OP_CAT,   16'h12AB, 16'h34CD, 1'b0, 1'b0, 4'd0,  16'hABCD, 4'b0100};
        vecs[5]  = '{OP_NEG,   16'h8000, 16'h0000, 1'b0, 1'b0, 4'd0,  16'h8000, 4'b0101};
        vecs[6]  = '{OP_NEG,   16'h0000, 16'h0000, 1'b0, 1'b0, 4'd0,  16'h0000, 4'b1010};
        vecs[7]  = '{OP_INC,   16'hFFFF, 16'h0000, 1'b0, 1'b0, 4'd0,  16'h0000, 4'b1010};
        vecs[8]  = '{OP_AND,   16'hF0F0, 16'h0FF0, 1'b0, 1'b0, 4'd0,  16'h00F0, 4'b0000};
        vecs[9]  = '{OP_OR,    16'hF000, 16'h000F, 1'b0, 1'b0, 4'd0,  16'hF00F, 4'b0100};
        vecs[10] = '{OP_ADD,   16'h0001, 16'h0001, 1'b1, 1'b0, 4'd0,  16'h0003, 4'b0000};
        vecs[11] = '{OP_ADD,   16'h8000, 16'h8000, 1'b0, 1'b0, 4'd0,  16'h0000, 4'b1011};
        vecs[12] = '{OP_ADD,   16'h0000, 16'h0000, 1'b0, 1'b1, 4'd0,  16'h0001, 4'b0000};
        vecs[13] = '{OP_ADD,   16'h0005, 16'h0005, 1'b1, 1'b1, 4'd0,  16'h000A, 4'b0000};
        vecs[14] = '{OP_ADDSH, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 4'd0,  16'hFFFE, 4'b0101};
        vecs[15] = '{OP_ADDSH, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 4'd15, 16'h0000, 4'b1010};
        vecs[16] = '{OP_ADD,   16'h0002, 16'h0003, 1'b0, 1'b0, 4'd0,  16'h0005, 4'b0000};

        bus.start  = 1'b0;
        bus.opc    = '0;
        bus.A      = '0;
        bus.B      = '0;
        bus.C      = 1'b0;
        bus.use_cf = 1'b0;
        bus.SHAMT  = '0;

        repeat (3) @(negedge clk);
        chk("reset.done", 32'(bus.done), 32'd0);
        chk("reset.in_ready", 32'(bus.in_ready), 32'd1);
        chk_result("reset", 16'h0000, 16'h0000, 4'b0000);
        rst = 1'b0;

        // Back-to-back issue: next start is driven while done is high
        @(negedge clk);
        drive(vecs[0].opc, vecs[0].a, vecs[0].b, vecs[0].c, vecs[0].ucf, vecs[0].sh);
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            chk($sformatf("v%0d.done", i), 32'(bus.done), 32'd1);
            chk($sformatf("v%0d.in_ready", i), 32'(bus.in_ready), 32'd1);
            chk_result($sformatf("v%0d", i), vecs[i].w, 16'h0000, vecs[i].f);
            if (i + 1 < NV) begin
                drive(vecs[i+1].opc, vecs[i+1].a, vecs[i+1].b, vecs[i+1].c, vecs[i+1].ucf,
                      vecs[i+1].sh);
            end else begin
                bus.start = 1'b0;
            end
        end
        @(negedge clk);
        chk("pulse.done_low", 32'(bus.done), 32'd0);
        chk_result("hold", 16'h0005, 16'h0000, 4'b0000);

        // MUL 3*5 with a stray start mid-flight
        run_mul("mul3x5", 16'd3, 16'd5, lat, low);
        chk("mul3x5.latency", 32'(lat), 32'd17);
        chk("mul3x5.busy_cycles", 32'(low), 32'd16);
        chk_result("mul3x5", 16'h000F, 16'h0000, 4'b0000);
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("mul3x5.extra_done", 32'(ndone), 32'd0);
        chk_result("mul3x5.hold", 16'h000F, 16'h0000, 4'b0000);

        run_mul("mul100", 16'h0100, 16'h0100, lat, low);
        chk("mul100.latency", 32'(lat), 32'd17);
        chk_result("mul100", 16'h0000, 16'h0001, 4'b1011);

        run_mul("mulffff", 16'hFFFF, 16'hFFFF, lat, low);
        chk_result("mulffff", 16'h0001, 16'hFFFE, 4'b0011);

        // Reset 5 cycles into a MUL aborts it silently
        @(negedge clk);
        drive(OP_MUL, 16'h0003, 16'h0005, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort.busy", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort.in_ready", 32'(bus.in_ready), 32'd1);
        chk("abort.done", 32'(bus.done), 32'd0);
        chk_result("abort", 16'h0000, 16'h0000, 4'b0000);
        ndone = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("abort.no_done", 32'(ndone), 32'd0);

        drive(OP_INC, 16'h7FFF, 16'h0000, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        bus.start = 1'b0;
        chk("inc.done", 32'(bus.done), 32'd1);
        chk_result("inc", 16'h8000, 16'h0000, 4'b0101);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
